register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-port register file that succeeds the single-write, two-read register file in the CORG datapath. It provides three combinational read ports and two prioritised write ports: port 0 serves ALU writeback and port 1 serves load writeback. It has optional same-cycle write-to-read bypass and an optional hardwired zero register. A per-register pending scoreboard lets the decode stage stall on outstanding loads. It sits between decode (reads, pending set) and the writeback stage (writes, pending clear).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, index width; NUM_REGS = 2**ADDR_W
- SP_INDEX, 6, index of the stack-pointer register
- SP_RESET, 256, reset value of register SP_INDEX (truncated to DATA_W)
- ZERO_REG, 0, when 1: register 0 always reads 0, and writes and pending-sets to it are ignored
- BYPASS, 1, when 1: same-cycle write data and pending clears are forwarded to the read outputs

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr0_en / wr0_addr / wr0_data  in  1 / ADDR_W / DATA_W  ALU writeback port
- wr1_en / wr1_addr / wr1_data  in  1 / ADDR_W / DATA_W  load writeback port; also clears pending
- pend_set_en / pend_set_addr  in  1 / ADDR_W  mark register as awaiting load data
- rdN_addr  in  ADDR_W  read address, N = 0..2
- rdN_data  out  DATA_W  read data, N = 0..2
- rdN_busy  out  1  pending bit of rdN_addr, N = 0..2

## Operation
- State:
  - regs[NUM_REGS] of DATA_W bits
  - pend[NUM_REGS] of 1 bit
- Reset (rst=1 at edge):
  - All regs are 0, except regs[SP_INDEX] = SP_RESET.
  - All pend bits are 0.
  - Writes and pend_set in the same cycle are ignored.
- Write:
  - At each edge, regs[wrK_addr] <= wrK_data when wrK_en.
  - Both ports to the same address: wr1 wins.
  - Different addresses: both are committed.
- Pending:
  - wr1_en clears pend[wr1_addr].
  - pend_set_en sets pend[pend_set_addr].
  - Set and clear on the same index in the same cycle: set wins (a new load was issued).
  - wr0 never touches pend.
- Read:
  - rdN_data = regs[rdN_addr], combinational.
  - With BYPASS=1, a write enabled this cycle to rdN_addr is forwarded (wr1 over wr0 over array).
  - rdN_busy = pend[rdN_addr]. With BYPASS=1 it is forced 0 when wr1 clears that index this cycle and no set targets it.
- ZERO_REG=1:
  - rdN_data = 0 and rdN_busy = 0 for address 0, regardless of bypass.
  - Writes and pend_set to 0 are dropped.
- Widths:
  - No arithmetic; data is stored as-is.
  - SP_RESET is truncated to DATA_W.

## Timing
- Write-to-read latency: 1 cycle with BYPASS=0, 0 cycles (combinational) with BYPASS=1.
- Pending set is visible on rdN_busy the cycle after pend_set_en.
- Pending clear latency:
  - With BYPASS=0, the clear is visible the cycle after wr1_en.
  - With BYPASS=1, the clear is visible in the same cycle as wr1_en.
- Output values during and immediately after reset:
  - rdN_data = 0, except SP_RESET when rdN_addr = SP_INDEX.
  - rdN_busy = 0.
  - Bypass stays active during rst: forwarded write data appears on outputs but is not committed.
- Reset mid-operation discards all pending bits; outstanding loads must be flushed by the pipeline.
- No handshake: ports are always ready; the caller guarantees the address is in range (any ADDR_W value is valid).

## Structure
- Shared package regfile_pkg:
  - default DATA_W and ADDR_W
  - register index constants (REG_SP = 6, REG_ZERO = 0)
  - SP_RESET default (256)
- Sub-module regfile_read_port: one instance per read port. It contains the address decode, the bypass priority mux and the busy forwarding logic, parametrised by DATA_W, ADDR_W, BYPASS and ZERO_REG.
- Top level holds the storage array, the write priority logic and the pend register.

## Test plan
- Reset: assert rst for 1 cycle then sweep rd0_addr 0..7 -> data 0 everywhere except addr 6 = 256; all busy = 0.
- Dual-write conflict: wr0 (r3, 0x1111) and wr1 (r3, 0x2222) in the same cycle -> r3 reads 0x2222 next cycle. Separate addresses r1 = 0xAAAA, r2 = 0x5555 -> both committed.
- Bypass: with BYPASS=1, wr0 r4 = 0xBEEF and rd1_addr = 4 -> rd1_data = 0xBEEF in the same cycle. With BYPASS=0 the same cycle shows the old value and the next cycle shows 0xBEEF.
- Scoreboard: pend_set r5 -> rd2_busy = 1 on the next cycle. Then wr1 r5 = 0x0042 -> busy 0 and data 0x0042 in the same cycle (BYPASS=1). Simultaneous pend_set and wr1 on r5 -> busy stays 1.
- ZERO_REG=1: wr0 r0 = 0xFFFF and pend_set r0 -> rd0_data = 0 and rd0_busy = 0 on all subsequent cycles.
- Reset mid-operation: pend set on r2, r7 = 0x1234 written, then rst pulsed with wr0 r7 = 0x9999 asserted -> after reset r7 = 0, r2 not busy, and r6 = 256.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the CORG multi-port register file: default geometry,
// architectural register indices and the stack-pointer reset value.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned ADDR_W_DEF   = 3;
    localparam int unsigned REG_ZERO     = 0;
    localparam int unsigned REG_SP       = 6;
    localparam int unsigned SP_RESET_DEF = 256;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array lookup, optional same-cycle write
// forwarding (wr1 over wr0 over array), pending-bit forwarding and zero register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic [DATA_W-1:0]      regs_i [2**ADDR_W],
    input  logic [(2**ADDR_W)-1:0] pend_i,
    input  logic                   wr0_en_i,
    input  logic [ADDR_W-1:0]      wr0_addr_i,
    input  logic [DATA_W-1:0]      wr0_data_i,
    input  logic                   wr1_en_i,
    input  logic [ADDR_W-1:0]      wr1_addr_i,
    input  logic [DATA_W-1:0]      wr1_data_i,
    input  logic                   pend_set_en_i,
    input  logic [ADDR_W-1:0]      pend_set_addr_i,
    input  logic [ADDR_W-1:0]      rd_addr_i,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic                   rd_busy_o
);

    logic wr0_hit, wr1_hit, set_hit, zero_hit;

    always_comb begin
        wr0_hit  = (BYPASS != 0) && wr0_en_i && (wr0_addr_i == rd_addr_i);
        wr1_hit  = (BYPASS != 0) && wr1_en_i && (wr1_addr_i == rd_addr_i);
        set_hit  = pend_set_en_i && (pend_set_addr_i == rd_addr_i);
        zero_hit = (ZERO_REG != 0) && (rd_addr_i == '0);

        rd_data_o = regs_i[rd_addr_i];
        rd_busy_o = pend_i[rd_addr_i];

        if (wr0_hit) rd_data_o = wr0_data_i;
        if (wr1_hit) begin
            rd_data_o = wr1_data_i;
            // a load completing this cycle clears busy unless a new load re-arms it
            if (!set_hit) rd_busy_o = 1'b0;
        end

        if (zero_hit) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two prioritised write ports (wr1 wins), three read
// ports and a per-register pending scoreboard set by decode, cleared by loads.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned SP_INDEX = REG_SP,
    parameter int unsigned SP_RESET = SP_RESET_DEF,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              pend_set_en,
    input  logic [ADDR_W-1:0] pend_set_addr,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    output logic              rd0_busy,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    localparam int unsigned       NUM_REGS   = 2**ADDR_W;
    localparam logic [DATA_W-1:0] SP_RST_VAL = DATA_W'(SP_RESET);

    logic [DATA_W-1:0]   regs_q  [NUM_REGS];
    logic [DATA_W-1:0]   regs_d  [NUM_REGS];
    logic [DATA_W-1:0]   regs_rd [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d, pend_rd;

    function automatic logic [DATA_W-1:0] reset_word(input int unsigned idx);
        return (idx == SP_INDEX) ? SP_RST_VAL : '0;
    endfunction

    function automatic logic dropped(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr0_en && !dropped(wr0_addr)) regs_d[wr0_addr] = wr0_data;
        if (wr1_en && !dropped(wr1_addr)) begin
            regs_d[wr1_addr] = wr1_data;
            pend_d[wr1_addr] = 1'b0;
        end
        if (pend_set_en && !dropped(pend_set_addr)) pend_d[pend_set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= reset_word(i);
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // while rst is held the ports already show the reset image; bypass stays live
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_rd[i] = rst ? reset_word(i) : regs_q[i];
        pend_rd = rst ? '0 : pend_q;
    end

    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd0 (
        .regs_i(regs_rd), .pend_i(pend_rd),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .pend_set_en_i(pend_set_en), .pend_set_addr_i(pend_set_addr),
        .rd_addr_i(rd0_addr), .rd_data_o(rd0_data), .rd_busy_o(rd0_busy)
    );

    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd1 (
        .regs_i(regs_rd), .pend_i(pend_rd),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .pend_set_en_i(pend_set_en), .pend_set_addr_i(pend_set_addr),
        .rd_addr_i(rd1_addr), .rd_data_o(rd1_data), .rd_busy_o(rd1_busy)
    );

    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd2 (
        .regs_i(regs_rd), .pend_i(pend_rd),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .pend_set_en_i(pend_set_en), .pend_set_addr_i(pend_set_addr),
        .rd_addr_i(rd2_addr), .rd_data_o(rd2_data), .rd_busy_o(rd2_busy)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: one instance with bypass (no zero register) and
// one without bypass but with the zero register, driven by identical stimulus.
`timescale 1ns/1ps
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr0_en, wr1_en, pend_set_en;
    logic [2:0]  wr0_addr, wr1_addr, pend_set_addr;
    logic [15:0] wr0_data, wr1_data;
    logic [2:0]  rd_addr [3];
    logic [15:0] a_data [3];
    logic [15:0] b_data [3];
    logic        a_busy [3];
    logic        b_busy [3];

    always #5 clk = ~clk;

    register_file_mp dut_a (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
        .rd0_addr(rd_addr[0]), .rd1_addr(rd_addr[1]), .rd2_addr(rd_addr[2]),
        .rd0_data(a_data[0]), .rd1_data(a_data[1]), .rd2_data(a_data[2]),
        .rd0_busy(a_busy[0]), .rd1_busy(a_busy[1]), .rd2_busy(a_busy[2])
    );

    register_file_mp #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
        .rd0_addr(rd_addr[0]), .rd1_addr(rd_addr[1]), .rd2_addr(rd_addr[2]),
        .rd0_data(b_data[0]), .rd1_data(b_data[1]), .rd2_data(b_data[2]),
        .rd0_busy(b_busy[0]), .rd1_busy(b_busy[1]), .rd2_busy(b_busy[2])
    );

    typedef struct {
        logic              rst;
        logic              w0e;
        logic [2:0]        w0a;
        logic [15:0]       w0d;
        logic              w1e;
        logic [2:0]        w1a;
        logic [15:0]       w1d;
        logic              pse;
        logic [2:0]        psa;
        logic [2:0][2:0]   ra;
        logic [2:0][15:0]  ea;
        logic [2:0]        ba;
        logic [2:0][15:0]  eb;
        logic [2:0]        bb;
    } vec_t;

    typedef struct {
        int               id;
        logic [2:0][15:0] ea;
        logic [2:0]       ba;
        logic [2:0][15:0] eb;
        logic [2:0]       bb;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // busy arguments are {rd2, rd1, rd0}
    function automatic vec_t mk(input int r, input int w0e, input int w0a, input int w0d,
                                input int w1e, input int w1a, input int w1d,
                                input int pse, input int psa,
                                input int r0, input int r1, input int r2,
                                input int a0, input int a1, input int a2, input int ba,
                                input int b0, input int b1, input int b2, input int bb);
        vec_t v;
        v.rst = (r != 0);
        v.w0e = (w0e != 0); v.w0a = 3'(w0a); v.w0d = 16'(w0d);
        v.w1e = (w1e != 0); v.w1a = 3'(w1a); v.w1d = 16'(w1d);
        v.pse = (pse != 0); v.psa = 3'(psa);
        v.ra[0] = 3'(r0); v.ra[1] = 3'(r1); v.ra[2] = 3'(r2);
        v.ea[0] = 16'(a0); v.ea[1] = 16'(a1); v.ea[2] = 16'(a2); v.ba = 3'(ba);
        v.eb[0] = 16'(b0); v.eb[1] = 16'(b1); v.eb[2] = 16'(b2); v.bb = 3'(bb);
        return v;
    endfunction

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        @(posedge clk);
        #1;
        rst = v.rst;
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        pend_set_en = v.pse; pend_set_addr = v.psa;
        for (int p = 0; p < 3; p++) rd_addr[p] = v.ra[p];
        e.id = id; e.ea = v.ea; e.ba = v.ba; e.eb = v.eb; e.bb = v.bb;
        sb_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
            return;
        end
        e = sb_q.pop_front();
        n_vec++;
        for (int p = 0; p < 3; p++) begin
            if (a_data[p] !== e.ea[p] || a_busy[p] !== e.ba[p]) begin
                n_err++;
                $display("FAIL vec%0d bypass_dut rd%0d: data=%h busy=%b, required data=%h busy=%b",
                         e.id, p, a_data[p], a_busy[p], e.ea[p], e.ba[p]);
            end
            if (b_data[p] !== e.eb[p] || b_busy[p] !== e.bb[p]) begin
                n_err++;
                $display("FAIL vec%0d nobypass_zero_dut rd%0d: data=%h busy=%b, required data=%h busy=%b",
                         e.id, p, b_data[p], b_busy[p], e.eb[p], e.bb[p]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [$];
        vec_t v;

        rst = 1'b1;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        pend_set_en = 1'b0; pend_set_addr = '0;
        for (int p = 0; p < 3; p++) rd_addr[p] = '0;
        repeat (2) @(posedge clk);

        // reset sweep: all three ports follow the same address
        for (int a = 0; a < 8; a++) begin
            int ev;
            ev = (a == 6) ? 'h0100 : 0;
            drive(mk(0, 0,0,0, 0,0,0, 0,0, a,a,a, ev,ev,ev,0, ev,ev,ev,0), 100 + a);
            check();
        end

        // dual-write conflict and separate-address commit
        vecs.push_back(mk(0, 1,3,'h1111, 1,3,'h2222, 0,0, 3,1,2, 'h2222,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 3,0,0, 'h2222,0,0,0, 'h2222,0,0,0));
        vecs.push_back(mk(0, 1,1,'hAAAA, 1,2,'h5555, 0,0, 1,2,3, 'hAAAA,'h5555,'h2222,0, 0,0,'h2222,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 1,2,3, 'hAAAA,'h5555,'h2222,0, 'hAAAA,'h5555,'h2222,0));
        // write-to-read latency
        vecs.push_back(mk(0, 1,4,'hBEEF, 0,0,0, 0,0, 0,4,6, 0,'hBEEF,'h0100,0, 0,0,'h0100,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,4,6, 0,'hBEEF,'h0100,0, 0,'hBEEF,'h0100,0));
        // pending set, clear, and set+clear collisions
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 1,5, 5,5,5, 0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,1,5, 0,'hAAAA,0,'b100, 0,'hAAAA,0,'b100));
        vecs.push_back(mk(0, 0,0,0, 1,5,'h0042, 0,0, 5,4,5, 'h0042,'hBEEF,'h0042,0, 0,'hBEEF,0,'b101));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 5,5,5, 'h0042,'h0042,'h0042,0, 'h0042,'h0042,'h0042,0));
        vecs.push_back(mk(0, 0,0,0, 1,5,'h0077, 1,5, 5,3,5, 'h0077,'h2222,'h0077,0, 'h0042,'h2222,'h0042,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 5,3,5, 'h0077,'h2222,'h0077,'b101, 'h0077,'h2222,'h0077,'b101));
        vecs.push_back(mk(0, 0,0,0, 1,5,'h0088, 1,5, 5,5,5, 'h0088,'h0088,'h0088,'b111, 'h0077,'h0077,'h0077,'b111));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 5,5,5, 'h0088,'h0088,'h0088,'b111, 'h0088,'h0088,'h0088,'b111));
        vecs.push_back(mk(0, 0,0,0, 1,5,'h0099, 0,0, 5,5,5, 'h0099,'h0099,'h0099,0, 'h0088,'h0088,'h0088,'b111));
        // register 0: ordinary in the bypass instance, hardwired zero in the other
        vecs.push_back(mk(0, 1,0,'hFFFF, 0,0,0, 1,0, 0,0,0, 'hFFFF,'hFFFF,'hFFFF,0, 0,0,0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,1,0, 'hFFFF,'hAAAA,'hFFFF,'b101, 0,'hAAAA,0,0));
        vecs.push_back(mk(0, 0,0,0, 1,0,'h1234, 0,0, 0,0,0, 'h1234,'h1234,'h1234,0, 0,0,0,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,2,0, 'h1234,'h5555,'h1234,0, 0,'h5555,0,0));
        // reset in the middle of operation
        vecs.push_back(mk(0, 1,7,'h1234, 0,0,0, 1,2, 7,2,6, 'h1234,'h5555,'h0100,0, 0,'h5555,'h0100,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7,2,6, 'h1234,'h5555,'h0100,'b010, 'h1234,'h5555,'h0100,'b010));
        vecs.push_back(mk(1, 1,7,'h9999, 0,0,0, 0,0, 7,2,6, 'h9999,0,'h0100,0, 0,0,'h0100,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 7,2,6, 0,0,'h0100,0, 0,0,'h0100,0));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 3,1,5, 0,0,0,0, 0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v, i);
            check();
        end

        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
